pwm_multi: RTL and testbench
============================

PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter N_CH, default 4, number of PWM channels (1..16).
REQ-002 Parameter PERIOD, default 1000000, counter period in clk cycles (50 Hz at 50 MHz); minimum 2.
REQ-003 Parameter CNT_W, default 20, counter and duty width; 2^CNT_W SHALL be > PERIOD.
REQ-004 Parameter CENTER, default 0; 0 = edge-aligned, 1 = center-aligned (up/down counter).
REQ-005 Parameter INV, default all zeros, N_CH-bit polarity mask; bit set inverts that channel's output.
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 en  input  1  run enable; low freezes the counter at 0 and idles outputs.
REQ-009 wr_en  input  1  duty write strobe, one write per asserted cycle.
REQ-010 wr_ch  input  4  target channel index.
REQ-011 wr_duty  input  CNT_W  duty value in clk cycles (high time per half-frame in center mode).
REQ-012 pwm_out  output  N_CH  registered PWM outputs.
REQ-013 frame_start  output  1  one-cycle pulse on every period boundary.
REQ-014 wr_err  output  1  one-cycle pulse when a write targets wr_ch >= N_CH.

Function
REQ-015 Edge mode: cnt counts 0..PERIOD-1 and wraps to 0; frame length PERIOD cycles.
REQ-016 Center mode: cnt counts up 0..PERIOD-1, then down PERIOD-1..0 (both endpoints held for one cycle each); frame length 2*PERIOD cycles.
REQ-017 The period boundary is each cycle in which cnt==0 and the counter is moving up (or is the first enabled cycle).
REQ-018 Each channel has a shadow duty register and an active duty register.
REQ-019 A write with wr_en=1 and wr_ch<N_CH SHALL update shadow[wr_ch] at the next clk edge; writes are accepted regardless of en.
REQ-020 A write with wr_ch>=N_CH SHALL change no register and SHALL pulse wr_err one cycle later.
REQ-021 On the period boundary cycle, active[i] SHALL load shadow[i] as registered before that edge; a write in the same cycle takes effect the following period.
REQ-022 Effective duty d[i] = min(active[i], PERIOD); values above PERIOD give 100 % duty.
REQ-023 pwm_out[i] SHALL be registered: next value = (cnt < d[i]) XOR INV[i], one cycle latency from cnt.
REQ-024 Edge mode: d[i]=D yields exactly D high cycles per PERIOD-cycle frame; D=0 constantly idle, D>=PERIOD constantly active.
REQ-025 Center mode: high region is 2*D cycles centered on the boundary (cnt < D on the down and up slopes).
REQ-026 frame_start SHALL be registered and pulse high the cycle after each boundary cycle.
REQ-027 en low: cnt held at 0, direction up, pwm_out = INV, frame_start = 0; active registers unchanged.
REQ-028 en rising: first enabled cycle is a boundary (active loads shadow), counting resumes from 0.
REQ-029 All state updates SHALL occur only on the rising edge of clk.

Reset
REQ-030 rst=1 at a clk edge SHALL set cnt=0, direction up, all shadow and active duties 0, pwm_out=INV, frame_start=0, wr_err=0.
REQ-031 rst SHALL take priority over en and wr_en; a write coincident with reset is discarded.
REQ-032 Reset mid-frame SHALL abort the frame; the first cycle after rst deasserts with en=1 is a boundary.

Verification (N_CH=2, PERIOD=10, CNT_W=4, INV=2'b10)
REQ-033 Reset then en=1, no writes -> pwm_out=2'b10 constantly, frame_start pulses every 10 cycles.
REQ-034 Write ch0=3 mid-frame -> current frame unchanged; next frame pwm_out[0] high exactly 3 cycles starting 1 cycle after boundary; repeats each frame.
REQ-035 Write ch1=15 -> from next frame pwm_out[1] constantly 0 (inverted 100 %); write ch1=0 -> constantly 1.
REQ-036 Write wr_ch=5 -> wr_err pulses one cycle, shadow values unchanged.
REQ-037 CENTER=1, ch0=2 -> frame 20 cycles, pwm_out[0] high 4 consecutive cycles straddling each boundary.
REQ-038 en low mid-frame for 7 cycles then high -> outputs idle during low, new frame starts at 0 with frame_start pulse on the next cycle.

Source files
------------

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared edge- or center-aligned counter.
// Each channel has a shadow duty register that is copied into its active register on every frame boundary.
module pwm_multi #(
    parameter int              N_CH   = 4,
    parameter int              PERIOD = 1000000,
    parameter int              CNT_W  = 20,
    parameter int              CENTER = 0,
    parameter logic [N_CH-1:0] INV    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_en,
    input  logic [3:0]       wr_ch,
    input  logic [CNT_W-1:0] wr_duty,
    output logic [N_CH-1:0]  pwm_out,
    output logic             frame_start,
    output logic             wr_err
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] PER  = CNT_W'(PERIOD);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             down;
    logic             down_nxt;
    logic             boundary;
    logic [CNT_W-1:0] shadow [N_CH];
    logic [CNT_W-1:0] active [N_CH];
    logic [CNT_W-1:0] eff    [N_CH];
    logic [N_CH-1:0]  level;

    // Holding cnt at 0 with direction up while disabled makes the first enabled cycle a boundary.
    assign boundary = en && (cnt == '0) && !down;

    always_comb begin
        cnt_nxt  = cnt;
        down_nxt = down;
        if (!en) begin
            cnt_nxt  = '0;
            down_nxt = 1'b0;
        end else if (CENTER == 0) begin
            cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
        end else if (!down) begin
            if (cnt == LAST) down_nxt = 1'b1;
            else             cnt_nxt  = cnt + 1'b1;
        end else begin
            if (cnt == '0) down_nxt = 1'b0;
            else           cnt_nxt  = cnt - 1'b1;
        end
    end

    // On the boundary the freshly loaded shadow value already drives the comparison.
    always_comb begin
        level = '0;
        for (int i = 0; i < N_CH; i++) begin
            eff[i] = boundary ? shadow[i] : active[i];
            if (eff[i] > PER) eff[i] = PER;
            level[i] = (cnt < eff[i]) ^ INV[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            down        <= 1'b0;
            pwm_out     <= INV;
            frame_start <= 1'b0;
            wr_err      <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            cnt         <= cnt_nxt;
            down        <= down_nxt;
            frame_start <= boundary;
            wr_err      <= wr_en && (32'(wr_ch) >= 32'(N_CH));
            pwm_out     <= en ? level : INV;
            for (int i = 0; i < N_CH; i++) begin
                if (wr_en && (32'(wr_ch) == 32'(i))) shadow[i] <= wr_duty;
                if (boundary) active[i] <= shadow[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: one edge-aligned and one center-aligned instance
// (N_CH=2, PERIOD=10, INV=2'b10) sharing clock, reset and enable.
module tb_pwm_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_ch = '0;
    logic [3:0] wr_duty = '0;
    logic       c_wr_en = 1'b0;
    logic [3:0] c_wr_ch = '0;
    logic [3:0] c_wr_duty = '0;
    logic [1:0] e_pwm, c_pwm;
    logic       e_fs, c_fs, e_err, c_err;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    pwm_multi #(.N_CH(2), .PERIOD(10), .CNT_W(4), .CENTER(0), .INV(2'b10)) u_edge (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .pwm_out(e_pwm), .frame_start(e_fs), .wr_err(e_err)
    );

    pwm_multi #(.N_CH(2), .PERIOD(10), .CNT_W(4), .CENTER(1), .INV(2'b10)) u_center (
        .clk(clk), .rst(rst), .en(en), .wr_en(c_wr_en), .wr_ch(c_wr_ch), .wr_duty(c_wr_duty),
        .pwm_out(c_pwm), .frame_start(c_fs), .wr_err(c_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s @%0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic drive_wr(input logic [3:0] ch, input logic [3:0] duty);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_duty = duty;
    endtask

    task automatic drive_c_wr(input logic [3:0] ch, input logic [3:0] duty);
        c_wr_en   = 1'b1;
        c_wr_ch   = ch;
        c_wr_duty = duty;
    endtask

    initial begin
        logic e0, e1, c0;
        int   p;

        // Reset state
        tick();
        tick();
        check_eq("rst_e_pwm", e_pwm, 2'b10);
        check_eq("rst_c_pwm", c_pwm, 2'b10);
        check_eq("rst_e_fs", e_fs, 1'b0);
        check_eq("rst_e_err", e_err, 1'b0);

        // Run: writes at fixed cycles, j = index of the edge since enable
        rst = 1'b0;
        en  = 1'b1;
        for (int j = 0; j < 84; j++) begin
            wr_en   = 1'b0;
            c_wr_en = 1'b0;
            case (j)
                4:  begin drive_wr(4'd0, 4'd3); drive_c_wr(4'd0, 4'd2); end
                33: drive_wr(4'd1, 4'd15);
                36: drive_wr(4'd5, 4'd7);
                45: drive_wr(4'd1, 4'd0);
                60: drive_wr(4'd0, 4'd5);
                default: ;
            endcase
            tick();
            e0 = (j < 10) ? 1'b0 : (j < 70) ? ((j % 10) < 3) : ((j % 10) < 5);
            e1 = !((j >= 40) && (j < 50));
            check_eq("edge_pwm", e_pwm, {e1, e0});
            check_eq("edge_fs", e_fs, (j % 10) == 0);
            check_eq("edge_err", e_err, j == 36);
            p  = j % 20;
            c0 = (j >= 20) && ((p < 2) || (p >= 18));
            check_eq("ctr_pwm", c_pwm, {1'b1, c0});
            check_eq("ctr_fs", c_fs, p == 0);
            check_eq("ctr_err", c_err, 1'b0);
        end
        wr_en   = 1'b0;
        c_wr_en = 1'b0;

        // Disable mid-frame for 7 cycles
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check_eq("off_e_pwm", e_pwm, 2'b10);
            check_eq("off_c_pwm", c_pwm, 2'b10);
            check_eq("off_e_fs", e_fs, 1'b0);
            check_eq("off_c_fs", c_fs, 1'b0);
        end
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_eq("resume_e_pwm", e_pwm, {1'b1, 1'(((k % 10) < 5))});
            check_eq("resume_e_fs", e_fs, (k % 10) == 0);
            check_eq("resume_c_pwm", c_pwm, {1'b1, 1'(k < 2)});
            check_eq("resume_c_fs", c_fs, k == 0);
        end

        // Reset mid-frame with a coincident write that must be discarded
        rst = 1'b1;
        drive_wr(4'd0, 4'd7);
        tick();
        wr_en = 1'b0;
        rst   = 1'b0;
        check_eq("midrst_e_pwm", e_pwm, 2'b10);
        check_eq("midrst_e_fs", e_fs, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tick();
            check_eq("post_rst_e_pwm", e_pwm, 2'b10);
            check_eq("post_rst_e_fs", e_fs, (k % 10) == 0);
            check_eq("post_rst_c_pwm", c_pwm, 2'b10);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
